// File: rtl/pcoeff_pkg.sv
// pcoeff_pkg: shared constants and default-width types for the p-coefficient accumulator
package pcoeff_pkg;
  localparam int SUM_WIDTH_DEFAULT = 48;
  localparam int COUNT_WIDTH_DEFAULT = 24;
  localparam int TAG_WIDTH_DEFAULT = 8;
  localparam int MAX_CONNECT_DEFAULT = 35;
  typedef logic [SUM_WIDTH_DEFAULT-1:0] pcoeff_t;
  typedef struct packed {
    pcoeff_t sum;
    logic [COUNT_WIDTH_DEFAULT-1:0] count;
    logic [TAG_WIDTH_DEFAULT-1:0] tag;
  } top_result_t;
endpackage

// File: rtl/pcoeff_decode.sv
// pcoeff_decode: registered 2^count decode with range check (in: valid/count/last/tag, out: v1/p1/last1/tag1/range_err1)
module pcoeff_decode
  import pcoeff_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_WIDTH_DEFAULT,
  parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
  parameter int MAX_CONNECT = MAX_CONNECT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [5:0]           count_i,
  input  logic                 last_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 v1,
  output logic [SUM_WIDTH-1:0] p1,
  output logic                 last1,
  output logic [TAG_WIDTH-1:0] tag1,
  output logic                 range_err1
);
  typedef struct packed {
    logic v;
    logic [SUM_WIDTH-1:0] p;
    logic last;
    logic [TAG_WIDTH-1:0] tag;
    logic rerr;
  } s1_t;
  s1_t s1_d, s1_q;
  logic range_d;
  always_comb begin
    range_d = int'(count_i) > MAX_CONNECT;
    s1_d = '{v: valid_i, p: range_d ? '0 : SUM_WIDTH'(1) << count_i, last: last_i, tag: tag_i, rerr: range_d};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) s1_q <= '0;
    else s1_q <= s1_d;
  assign v1 = s1_q.v;
  assign p1 = s1_q.p;
  assign last1 = s1_q.last;
  assign tag1 = s1_q.tag;
  assign range_err1 = s1_q.rerr;
endmodule

// File: rtl/pcoeff_sum_accumulator.sv
// pcoeff_sum_accumulator: sums 2^connectCount per top, emits {sum,count,tag} via valid/ready register with sticky errors
module pcoeff_sum_accumulator
  import pcoeff_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_WIDTH_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
  parameter int MAX_CONNECT = MAX_CONNECT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   resultValid,
  input  logic [5:0]             connectCount,
  input  logic                   lastOfTop,
  input  logic [TAG_WIDTH-1:0]   topTag,
  output logic                   sumValid,
  input  logic                   sumReady,
  output logic [SUM_WIDTH-1:0]   pcoeffSum,
  output logic [COUNT_WIDTH-1:0] botCount,
  output logic [TAG_WIDTH-1:0]   sumTag,
  output logic                   errOverflow,
  output logic                   errRange,
  output logic                   errDropped
);
  typedef struct packed {
    logic [SUM_WIDTH-1:0] sum;
    logic [COUNT_WIDTH-1:0] count;
    logic [TAG_WIDTH-1:0] tag;
  } res_t;
  logic v1, last1, range_err1;
  logic [SUM_WIDTH-1:0] p1;
  logic [TAG_WIDTH-1:0] tag1;
  pcoeff_decode #(.SUM_WIDTH(SUM_WIDTH), .TAG_WIDTH(TAG_WIDTH), .MAX_CONNECT(MAX_CONNECT)) u_decode (
    .clk(clk), .rst(rst), .valid_i(resultValid), .count_i(connectCount), .last_i(lastOfTop), .tag_i(topTag),
    .v1(v1), .p1(p1), .last1(last1), .tag1(tag1), .range_err1(range_err1)
  );
  logic [SUM_WIDTH-1:0] acc_d, acc_q;
  logic [COUNT_WIDTH-1:0] cnt_d, cnt_q;
  logic ovf_d, ovf_q, valid_d, valid_q;
  logic err_ovf_d, err_ovf_q, err_rng_d, err_rng_q, err_drop_d, err_drop_q;
  res_t out_d, out_q;
  logic [SUM_WIDTH:0] sum_x;
  logic [COUNT_WIDTH:0] cnt_x;
  logic wrap, close, take;
  always_comb begin
    sum_x = {1'b0, acc_q} + {1'b0, p1};
    cnt_x = {1'b0, cnt_q} + (COUNT_WIDTH+1)'(1);
    wrap = sum_x[SUM_WIDTH] | cnt_x[COUNT_WIDTH];
    close = v1 & last1;
    take = ~valid_q | sumReady;
    acc_d = !v1 ? acc_q : last1 ? '0 : sum_x[SUM_WIDTH-1:0];
    cnt_d = !v1 ? cnt_q : last1 ? '0 : cnt_x[COUNT_WIDTH-1:0];
    ovf_d = !v1 ? ovf_q : last1 ? 1'b0 : ovf_q | wrap;
    out_d = close & take ? '{sum: sum_x[SUM_WIDTH-1:0], count: cnt_x[COUNT_WIDTH-1:0], tag: tag1} : out_q;
    valid_d = close & take ? 1'b1 : valid_q & ~sumReady;
    err_ovf_d = err_ovf_q | (close & (ovf_q | wrap));
    err_rng_d = err_rng_q | (v1 & range_err1);
    err_drop_d = err_drop_q | (close & ~take);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      out_q <= '0;
      valid_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_rng_q <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      out_q <= out_d;
      valid_q <= valid_d;
      err_ovf_q <= err_ovf_d;
      err_rng_q <= err_rng_d;
      err_drop_q <= err_drop_d;
    end
  assign sumValid = valid_q;
  assign pcoeffSum = out_q.sum;
  assign botCount = out_q.count;
  assign sumTag = out_q.tag;
  assign errOverflow = err_ovf_q;
  assign errRange = err_rng_q;
  assign errDropped = err_drop_q;
endmodule

// File: tb/tb_pcoeff_sum_accumulator.sv
// tb_pcoeff_sum_accumulator: directed-vector bench for default and 8-bit-sum builds
module tb_pcoeff_sum_accumulator;
  logic clk = 1'b0, rst = 1'b0;
  logic resultValid = 1'b0, lastOfTop = 1'b0, sumReady = 1'b0;
  logic [5:0] connectCount = '0;
  logic [7:0] topTag = '0;
  logic sumValid, errOverflow, errRange, errDropped;
  logic [47:0] pcoeffSum;
  logic [23:0] botCount;
  logic [7:0] sumTag;
  logic sumValid8, errOverflow8, errRange8, errDropped8;
  logic [7:0] pcoeffSum8;
  logic [23:0] botCount8;
  logic [7:0] sumTag8;
  int nvec = 0, nmiss = 0;
  always #5 clk = ~clk;
  pcoeff_sum_accumulator dut (
    .clk(clk), .rst(rst), .resultValid(resultValid), .connectCount(connectCount), .lastOfTop(lastOfTop),
    .topTag(topTag), .sumValid(sumValid), .sumReady(sumReady), .pcoeffSum(pcoeffSum), .botCount(botCount),
    .sumTag(sumTag), .errOverflow(errOverflow), .errRange(errRange), .errDropped(errDropped)
  );
  pcoeff_sum_accumulator #(.SUM_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .resultValid(resultValid), .connectCount(connectCount), .lastOfTop(lastOfTop),
    .topTag(topTag), .sumValid(sumValid8), .sumReady(sumReady), .pcoeffSum(pcoeffSum8), .botCount(botCount8),
    .sumTag(sumTag8), .errOverflow(errOverflow8), .errRange(errRange8), .errDropped(errDropped8)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic beat(input logic v, input logic [5:0] c, input logic l, input logic [7:0] t);
    resultValid = v;
    connectCount = c;
    lastOfTop = l;
    topTag = t;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    beat(1'b0, 6'd0, 1'b0, 8'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", sumValid, 0);
    chk("rst_sum", pcoeffSum, 0);
    chk("rst_errs", {errOverflow, errRange, errDropped}, 0);
    rst = 1'b1;
    sumReady = 1'b1;
    idle();
    beat(1, 0, 0, 0);
    beat(1, 1, 0, 0);
    beat(1, 3, 1, 9);
    chk("t1_n1_valid", sumValid, 0);
    idle();
    chk("t1_valid", sumValid, 1);
    chk("t1_sum", pcoeffSum, 11);
    chk("t1_cnt", botCount, 3);
    chk("t1_tag", sumTag, 9);
    idle();
    chk("t1_drain", sumValid, 0);
    beat(1, 5, 1, 7);
    beat(1, 2, 1, 8);
    chk("t2a_valid", sumValid, 1);
    chk("t2a", {pcoeffSum, botCount, sumTag}, {48'd32, 24'd1, 8'd7});
    idle();
    chk("t2b_valid", sumValid, 1);
    chk("t2b", {pcoeffSum, botCount, sumTag}, {48'd4, 24'd1, 8'd8});
    idle();
    chk("t2_drain", sumValid, 0);
    sumReady = 1'b0;
    beat(1, 1, 1, 1);
    idle();
    beat(1, 2, 1, 2);
    idle();
    idle();
    chk("t3_valid", sumValid, 1);
    chk("t3_held", {pcoeffSum, botCount, sumTag}, {48'd2, 24'd1, 8'd1});
    chk("t3_drop", errDropped, 1);
    idle();
    chk("t3_stable", {sumValid, pcoeffSum, botCount}, {1'b1, 48'd2, 24'd1});
    sumReady = 1'b1;
    idle();
    chk("t3_release", sumValid, 0);
    chk("t3_range_clear", errRange, 0);
    beat(1, 40, 0, 0);
    beat(1, 1, 1, 3);
    idle();
    chk("t4", {sumValid, pcoeffSum, botCount}, {1'b1, 48'd2, 24'd2});
    chk("t4_range", errRange, 1);
    chk("t4_ovf", errOverflow, 0);
    idle();
    beat(1, 7, 0, 0);
    beat(1, 7, 1, 4);
    idle();
    chk("t5_w8", {sumValid8, pcoeffSum8, botCount8}, {1'b1, 8'd0, 24'd2});
    chk("t5_ovf8", errOverflow8, 1);
    chk("t5_w48_sum", pcoeffSum, 256);
    chk("t5_w48_ovf", errOverflow, 0);
    idle();
    beat(1, 3, 1, 5);
    idle();
    chk("t5_next8", {sumValid8, pcoeffSum8, botCount8, sumTag8}, {1'b1, 8'd8, 24'd1, 8'd5});
    idle();
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 0);
    resultValid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_async", {sumValid, errOverflow, errRange, errDropped, sumValid8, errOverflow8}, 0);
    chk("t6_async_sum", pcoeffSum, 0);
    #2 rst = 1'b1;
    beat(1, 4, 1, 6);
    idle();
    chk("t6", {sumValid, pcoeffSum, botCount, sumTag}, {1'b1, 48'd16, 24'd1, 8'd6});
    chk("t6_errs", {errOverflow, errRange, errDropped}, 0);
    chk("t6_errs8", {errOverflow8, errRange8, errDropped8}, 0);
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
